virtio_csr_mq: RTL and testbench

//  Parametrised multi-queue virtio legacy (0.9.5) PCI register file on a BRAM-controller port (PCIe BAR -> AXI BRAM ctrl).

---
 rtl/virtio_csr_pkg.sv | 30 +++
 rtl/virtio_notify_arb.sv | 79 +++++++
 rtl/virtio_csr_mq.sv | 186 ++++++++++++++++++
 tb/tb_virtio_csr_mq.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/virtio_csr_pkg.sv
// Shared constants for the virtio legacy PCI register file: register offsets,
// device status bit positions, ISR bit indices and the address decode struct.
package virtio_csr_pkg;

    localparam int OFF_DEV_FEAT   = 'h00;
    localparam int OFF_GUEST_FEAT = 'h04;
    localparam int OFF_QADDR      = 'h08;
    localparam int OFF_QSEL       = 'h0C;
    localparam int OFF_ISR_ST     = 'h10;
    localparam int OFF_MSIX       = 'h14;
    localparam int OFF_CFG        = 'h18;

    localparam int ST_ACK       = 0;
    localparam int ST_DRIVER    = 1;
    localparam int ST_DRIVER_OK = 2;
    localparam int ST_FAILED    = 7;

    localparam int ISR_QUEUE = 0;
    localparam int ISR_CFG   = 1;

    typedef struct packed {
        logic dev_feat;
        logic guest_feat;
        logic qaddr;
        logic qsel;
        logic isr_st;
        logic msix;
    } hit_t;

endpackage

// File: rtl/virtio_notify_arb.sv
// Queue-notify arbiter: one pending bit per queue, round-robin grant starting
// after the last granted queue, registered valid/ready output.
module virtio_notify_arb
#(
    parameter int NUM_Q = 3
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       set_i,
    input  logic [3:0] set_qid_i,
    input  logic       ntf_ready_i,
    output logic       ntf_valid_o,
    output logic [3:0] ntf_qid_o
);

    logic [NUM_Q-1:0] pend_q, pend_d, set_vec, acc_vec;
    logic [3:0]       ptr_q, ptr_d, qid_q, qid_d;
    logic             valid_q, valid_d, accept, found;
    logic [4:0]       idx;

    // Handshake: ntf_valid_o/ntf_qid_o hold until ntf_valid_o && ntf_ready_i on a rising edge.
    assign accept = valid_q && ntf_ready_i;

    always_comb begin
        set_vec = '0;
        acc_vec = '0;
        for (int i = 0; i < NUM_Q; i++) begin
            set_vec[i] = set_i && (set_qid_i == 4'(i));
            acc_vec[i] = accept && (qid_q == 4'(i));
        end
        // A same-cycle re-notify of the accepted queue survives the clear.
        pend_d  = (pend_q & ~acc_vec) | set_vec;
        valid_d = valid_q;
        qid_d   = qid_q;
        ptr_d   = ptr_q;
        found   = 1'b0;
        idx     = '0;
        if (!valid_q || accept) begin
            valid_d = 1'b0;
            for (int k = 0; k < NUM_Q; k++) begin
                idx = 5'(ptr_q) + 5'(k);
                if (idx >= 5'(NUM_Q)) idx = idx - 5'(NUM_Q);
                for (int i = 0; i < NUM_Q; i++) begin
                    if (!found && idx == 5'(i) && pend_d[i]) begin
                        found   = 1'b1;
                        valid_d = 1'b1;
                        qid_d   = 4'(i);
                        ptr_d   = (i == NUM_Q - 1) ? 4'd0 : 4'(i + 1);
                    end
                end
            end
        end
        if (clr_i) begin
            pend_d  = '0;
            valid_d = 1'b0;
            qid_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q  <= '0;
            ptr_q   <= '0;
            qid_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            ptr_q   <= ptr_d;
            qid_q   <= qid_d;
            valid_q <= valid_d;
        end
    end

    assign ntf_valid_o = valid_q;
    assign ntf_qid_o   = qid_q;

endmodule

// File: rtl/virtio_csr_mq.sv
// Multi-queue virtio legacy PCI register file on a BRAM-controller port:
// per-queue banks selected by Queue Select, status/soft reset, read-to-clear ISR.
module virtio_csr_mq
    import virtio_csr_pkg::*;
#(
    parameter int          NUM_Q        = 3,
    parameter logic [15:0] QSIZE        = 16'h0100,
    parameter logic [31:0] DEV_FEATURES = 32'h0000_0000,
    parameter int          CFG_WORDS    = 8,
    parameter int          ADDR_W       = 12
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [3:0]            we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [31:0]           din,
    output logic [31:0]           dout,
    output logic [31:0]           guest_feat,
    output logic [7:0]            dev_status,
    output logic                  drv_ok,
    output logic [NUM_Q*32-1:0]   q_pfn,
    output logic [NUM_Q*16-1:0]   q_msix,
    output logic [15:0]           cfg_msix,
    output logic                  soft_rst,
    output logic                  ntf_valid,
    output logic [3:0]            ntf_qid,
    input  logic                  ntf_ready,
    input  logic                  isr_q_set,
    input  logic                  isr_cfg_set,
    output logic                  irq
);

    logic [31:0] guest_feat_q, dout_q, rd_data, cur_qaddr, cfg_rd;
    logic [15:0] qsel_q, cfg_msix_q, cur_qmsix;
    logic [7:0]  status_q, isr_q, isr_d;
    logic        irq_q, soft_rst_q;
    logic [31:0] qaddr_q [NUM_Q];
    logic [15:0] qmsix_q [NUM_Q];
    logic [31:0] cfg_q [CFG_WORDS];
    logic [CFG_WORDS-1:0] cfg_sel;

    logic [ADDR_W-1:0] byte_addr;
    hit_t hit;
    logic rd, sel_valid, cfg_hit, notify_ok, unused_addr_lsb;
    logic wr_gf, wr_qaddr, wr_qsel, wr_status, wr_notify, wr_qmsix, wr_cmsix, soft_clr;

    assign unused_addr_lsb = ^addr[1:0];
    assign byte_addr = {addr[ADDR_W-1:2], 2'b00};

    assign hit.dev_feat   = byte_addr == ADDR_W'(OFF_DEV_FEAT);
    assign hit.guest_feat = byte_addr == ADDR_W'(OFF_GUEST_FEAT);
    assign hit.qaddr      = byte_addr == ADDR_W'(OFF_QADDR);
    assign hit.qsel       = byte_addr == ADDR_W'(OFF_QSEL);
    assign hit.isr_st     = byte_addr == ADDR_W'(OFF_ISR_ST);
    assign hit.msix       = byte_addr == ADDR_W'(OFF_MSIX);

    assign rd        = en && (we == 4'b0000);
    assign sel_valid = qsel_q < 16'(NUM_Q);
    assign notify_ok = din[15:0] < 16'(NUM_Q);

    // A field is written only when every byte lane it spans is enabled.
    assign wr_gf     = en && hit.guest_feat && (&we);
    assign wr_qaddr  = en && hit.qaddr && (&we) && sel_valid;
    assign wr_qsel   = en && hit.qsel && (&we[3:2]);
    assign wr_status = en && hit.isr_st && we[2];
    assign wr_notify = en && hit.isr_st && (&we[1:0]);
    assign wr_qmsix  = en && hit.msix && (&we[3:2]) && sel_valid;
    assign wr_cmsix  = en && hit.msix && (&we[1:0]);
    assign soft_clr  = wr_status && (din[23:16] == 8'h00);

    always_comb begin
        cur_qaddr = '0;
        cur_qmsix = '0;
        for (int i = 0; i < NUM_Q; i++) begin
            if (qsel_q == 16'(i)) begin
                cur_qaddr = qaddr_q[i];
                cur_qmsix = qmsix_q[i];
            end
        end
        cfg_sel = '0;
        cfg_rd  = '0;
        for (int j = 0; j < CFG_WORDS; j++) begin
            cfg_sel[j] = byte_addr == ADDR_W'(OFF_CFG + 4 * j);
            if (cfg_sel[j]) cfg_rd = cfg_q[j];
        end
        cfg_hit = |cfg_sel;

        rd_data = '0;
        if (hit.dev_feat)        rd_data = DEV_FEATURES;
        else if (hit.guest_feat) rd_data = guest_feat_q;
        else if (hit.qaddr)      rd_data = cur_qaddr;
        else if (hit.qsel)       rd_data = {qsel_q, sel_valid ? QSIZE : 16'h0000};
        else if (hit.isr_st)     rd_data = {isr_q, status_q, 16'h0000};
        else if (hit.msix)       rd_data = {cur_qmsix, cfg_msix_q};
        else if (cfg_hit)        rd_data = cfg_rd;

        // Read-clear first, then new events, so an event coinciding with the read is kept.
        isr_d = isr_q;
        if (rd && hit.isr_st) isr_d = 8'h00;
        if (isr_q_set)        isr_d[ISR_QUEUE] = 1'b1;
        if (isr_cfg_set)      isr_d[ISR_CFG]   = 1'b1;
        if (soft_clr)         isr_d = 8'h00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            guest_feat_q <= '0;
            status_q     <= '0;
            qsel_q       <= '0;
            cfg_msix_q   <= '0;
            isr_q        <= '0;
            irq_q        <= 1'b0;
            soft_rst_q   <= 1'b0;
            dout_q       <= '0;
            for (int i = 0; i < NUM_Q; i++) begin
                qaddr_q[i] <= '0;
                qmsix_q[i] <= '0;
            end
        end else begin
            isr_q      <= isr_d;
            irq_q      <= |isr_d;
            soft_rst_q <= soft_clr;
            // Cfg RAM behaves read-first: a write access also returns the old word.
            if (rd || (en && cfg_hit)) dout_q <= rd_data;
            if (soft_clr) begin
                guest_feat_q <= '0;
                status_q     <= '0;
                qsel_q       <= '0;
                cfg_msix_q   <= '0;
                for (int i = 0; i < NUM_Q; i++) begin
                    qaddr_q[i] <= '0;
                    qmsix_q[i] <= '0;
                end
            end else begin
                if (wr_gf)     guest_feat_q <= din;
                if (wr_status) status_q     <= din[23:16];
                if (wr_qsel)   qsel_q       <= din[31:16];
                if (wr_cmsix)  cfg_msix_q   <= din[15:0];
                for (int i = 0; i < NUM_Q; i++) begin
                    if (wr_qaddr && qsel_q == 16'(i)) qaddr_q[i] <= din;
                    if (wr_qmsix && qsel_q == 16'(i)) qmsix_q[i] <= din[31:16];
                end
            end
        end
    end

    // Device config words: zeroed only by power-on reset, untouched by soft reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < CFG_WORDS; j++) cfg_q[j] <= '0;
        end else begin
            for (int j = 0; j < CFG_WORDS; j++) begin
                for (int b = 0; b < 4; b++) begin
                    if (en && cfg_sel[j] && we[b]) cfg_q[j][8*b +: 8] <= din[8*b +: 8];
                end
            end
        end
    end

    virtio_notify_arb #(.NUM_Q(NUM_Q)) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (soft_clr),
        .set_i       (wr_notify && notify_ok),
        .set_qid_i   (din[3:0]),
        .ntf_ready_i (ntf_ready),
        .ntf_valid_o (ntf_valid),
        .ntf_qid_o   (ntf_qid)
    );

    for (genvar i = 0; i < NUM_Q; i++) begin : g_q_out
        assign q_pfn[32*i +: 32]  = qaddr_q[i];
        assign q_msix[16*i +: 16] = qmsix_q[i];
    end

    assign dout       = dout_q;
    assign guest_feat = guest_feat_q;
    assign dev_status = status_q;
    assign drv_ok     = status_q[ST_DRIVER_OK];
    assign cfg_msix   = cfg_msix_q;
    assign soft_rst   = soft_rst_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_virtio_csr_mq.sv
// Directed bench for virtio_csr_mq: bus reads and notifications are checked
// against expected values queued when the stimulus is issued.
module tb_virtio_csr_mq;

  localparam logic [31:0] DEVF = 32'hA5A5_0F0F;

  logic        clk, rst_n, en;
  logic [3:0]  we;
  logic [11:0] addr;
  logic [31:0] din, dout, guest_feat;
  logic [7:0]  dev_status;
  logic        drv_ok, soft_rst, ntf_valid, ntf_ready, isr_q_set, isr_cfg_set, irq;
  logic [95:0] q_pfn;
  logic [47:0] q_msix;
  logic [15:0] cfg_msix;
  logic [3:0]  ntf_qid;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [3:0]  ntf_exp_q[$];

  virtio_csr_mq #(.DEV_FEATURES(DEVF)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .we(we), .addr(addr), .din(din), .dout(dout),
    .guest_feat(guest_feat), .dev_status(dev_status), .drv_ok(drv_ok), .q_pfn(q_pfn),
    .q_msix(q_msix), .cfg_msix(cfg_msix), .soft_rst(soft_rst), .ntf_valid(ntf_valid),
    .ntf_qid(ntf_qid), .ntf_ready(ntf_ready), .isr_q_set(isr_q_set),
    .isr_cfg_set(isr_cfg_set), .irq(irq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic bus_write(input logic [11:0] a, input logic [3:0] w, input logic [31:0] d);
    @(negedge clk);
    en = 1'b1; we = w; addr = a; din = d;
    @(negedge clk);
    en = 1'b0; we = 4'b0000;
  endtask

  task automatic bus_read(input string tag, input logic [11:0] a, input logic [31:0] e);
    logic [31:0] exp_v;
    exp_q.push_back(e);
    @(negedge clk);
    en = 1'b1; we = 4'b0000; addr = a;
    @(negedge clk);
    en = 1'b0;
    exp_v = exp_q.pop_front();
    check(tag, dout, exp_v);
  endtask

  task automatic pulse_isr(input logic qs, input logic cs);
    @(negedge clk);
    isr_q_set = qs; isr_cfg_set = cs;
    @(negedge clk);
    isr_q_set = 1'b0; isr_cfg_set = 1'b0;
  endtask

  task automatic drain_ntf(input string tag);
    logic [3:0] e;
    ntf_ready = 1'b1;
    for (int c = 0; c < 20 && ntf_exp_q.size() > 0; c++) begin
      if (ntf_valid) begin
        e = ntf_exp_q.pop_front();
        check(tag, ntf_qid, e);
      end
      @(negedge clk);
    end
    check({tag, "_left"}, ntf_exp_q.size(), 0);
    repeat (3) @(negedge clk);
    check({tag, "_idle"}, ntf_valid, 1'b0);
    ntf_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; we = '0; addr = '0; din = '0;
    ntf_ready = 1'b0; isr_q_set = 1'b0; isr_cfg_set = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dout", dout, 0);
    check("rst_pfn", q_pfn, 0);
    check("rst_misc", {guest_feat, dev_status, drv_ok, cfg_msix, soft_rst, ntf_valid, ntf_qid, irq, q_msix}, 0);
    rst_n = 1'b1;

    bus_read("dev_feat", 12'h000, DEVF);
    bus_read("qsize_sel0", 12'h00C, 32'h0000_0100);

    // queue address bank
    bus_write(12'h00C, 4'b1100, 32'h0001_0000);
    bus_write(12'h008, 4'b1111, 32'h0001_2340);
    bus_write(12'h00C, 4'b1100, 32'h0002_0000);
    bus_read("qaddr_sel2", 12'h008, 32'h0);
    bus_write(12'h00C, 4'b1100, 32'h0001_0000);
    bus_read("qaddr_sel1", 12'h008, 32'h0001_2340);
    check("q_pfn_q1", q_pfn[63:32], 32'h0001_2340);
    bus_write(12'h008, 4'b0111, 32'hFFFF_FFFF);
    bus_read("qaddr_partial", 12'h008, 32'h0001_2340);
    bus_write(12'h014, 4'b1111, 32'h0005_0009);
    bus_read("msix_sel1", 12'h014, 32'h0005_0009);
    check("q_msix_q1", q_msix[31:16], 16'h0005);
    check("cfg_msix", cfg_msix, 16'h0009);

    bus_write(12'h004, 4'b1111, 32'hCAFE_0001);
    bus_write(12'h004, 4'b0001, 32'h0000_0000);
    bus_read("guest_feat", 12'h004, 32'hCAFE_0001);
    check("guest_feat_out", guest_feat, 32'hCAFE_0001);

    // notify: first write is granted at once, the rest wait in round-robin order
    bus_write(12'h010, 4'b0011, 32'h2);
    bus_write(12'h010, 4'b0011, 32'h0);
    bus_write(12'h010, 4'b0011, 32'h2);
    repeat (2) @(negedge clk);
    check("ntf_hold", {ntf_valid, ntf_qid}, {1'b1, 4'd2});
    ntf_exp_q.push_back(4'd2);
    ntf_exp_q.push_back(4'd0);
    drain_ntf("ntf_rr");

    ntf_ready = 1'b1;
    bus_write(12'h010, 4'b0011, 32'h1);
    bus_write(12'h010, 4'b0011, 32'h1);
    check("ntf_renotify_kept", {ntf_valid, ntf_qid}, {1'b1, 4'd1});
    @(negedge clk);
    check("ntf_renotify_done", ntf_valid, 1'b0);
    ntf_ready = 1'b0;

    // ISR read-to-clear
    pulse_isr(1'b1, 1'b0);
    check("irq_set", irq, 1'b1);
    bus_read("isr_read", 12'h010, 32'h0100_0000);
    check("irq_cleared", irq, 1'b0);
    pulse_isr(1'b1, 1'b0);
    @(negedge clk);
    en = 1'b1; we = 4'b0000; addr = 12'h010; isr_cfg_set = 1'b1;
    @(negedge clk);
    en = 1'b0; isr_cfg_set = 1'b0;
    check("isr_read_race", dout, 32'h0100_0000);
    check("irq_kept", irq, 1'b1);
    bus_read("isr_cfg_kept", 12'h010, 32'h0200_0000);
    check("irq_after_cfg", irq, 1'b0);

    // cfg RAM: byte lanes, read-first on write, boundaries
    bus_write(12'h018, 4'b1111, 32'hDEAD_BEEF);
    bus_write(12'h01C, 4'b0101, 32'h1122_3344);
    bus_read("cfg0", 12'h018, 32'hDEAD_BEEF);
    bus_read("cfg1_lanes", 12'h01C, 32'h0022_0044);
    bus_write(12'h018, 4'b1111, 32'h0BAD_F00D);
    check("cfg_read_first", dout, 32'hDEAD_BEEF);
    bus_read("cfg0_new", 12'h018, 32'h0BAD_F00D);
    bus_write(12'h034, 4'b1111, 32'h7777_8888);
    bus_read("cfg_last", 12'h034, 32'h7777_8888);
    bus_read("unmapped", 12'h038, 32'h0);

    // status and soft reset
    bus_write(12'h010, 4'b0100, 32'h0007_0000);
    check("status_drv_ok", {dev_status, drv_ok}, {8'h07, 1'b1});
    bus_write(12'h010, 4'b0011, 32'h1);
    pulse_isr(1'b1, 1'b0);
    check("pre_soft_state", {ntf_valid, irq}, 2'b11);
    bus_write(12'h010, 4'b0100, 32'h0000_0000);
    check("soft_rst_pulse", soft_rst, 1'b1);
    check("soft_clr_pfn", q_pfn, 0);
    check("soft_clr_misc", {guest_feat, dev_status, drv_ok, cfg_msix, q_msix, irq, ntf_valid}, 0);
    @(negedge clk);
    check("soft_rst_end", soft_rst, 1'b0);
    ntf_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("soft_clr_pending", ntf_valid, 1'b0);
    ntf_ready = 1'b0;
    bus_read("soft_cfg_kept", 12'h018, 32'h0BAD_F00D);
    bus_read("soft_qsel", 12'h00C, 32'h0000_0100);
    bus_read("soft_isr", 12'h010, 32'h0);

    // out-of-range queue select and notify
    bus_write(12'h00C, 4'b1100, 32'h0005_0000);
    bus_write(12'h008, 4'b1111, 32'hFFFF_FFFF);
    bus_write(12'h014, 4'b1100, 32'h0007_0000);
    bus_read("qsel5_size", 12'h00C, 32'h0005_0000);
    @(negedge clk);
    check("dout_hold", dout, 32'h0005_0000);
    bus_read("qsel5_qaddr", 12'h008, 32'h0);
    bus_read("qsel5_msix", 12'h014, 32'h0);
    check("qsel5_banks", {q_pfn, q_msix}, 0);
    bus_write(12'h010, 4'b0011, 32'h5);
    bus_write(12'h010, 4'b0011, 32'h3);
    repeat (2) @(negedge clk);
    check("ntf_out_of_range", ntf_valid, 1'b0);
    bus_write(12'h010, 4'b0011, 32'h2);
    ntf_exp_q.push_back(4'd2);
    drain_ntf("ntf_last_q");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
